// File: rtl/bcd_counter_scan.sv
// Multi-digit 8421 BCD up/down counter with parallel load, wrap pulse and a
// time-multiplexed common-cathode seven-segment scan driver.

module bcd_digit_cell (
    input  logic [3:0] d,
    input  logic       up,
    input  logic       cin,
    output logic [3:0] nd,
    output logic       cout
);
    always_comb begin
        nd   = d;
        cout = 1'b0;
        if (cin) begin
            if (up) begin
                if (d >= 4'd9) begin
                    nd   = 4'd0;
                    cout = 1'b1;
                end else begin
                    nd = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    nd   = 4'd9;
                    cout = 1'b1;
                end else begin
                    nd = d - 4'd1;
                end
            end
        end
    end
endmodule

module bcd_counter_scan #(
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  wrap,
    output logic [8:0]            seg_led,
    output logic [DIGITS-1:0]     cat
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DIGITS-1:0][3:0] q_r, q_nxt, q_ld;
    logic [DIGITS:0]        carry;
    logic [DW-1:0]          div;
    logic [IW-1:0]          idx;
    logic [3:0]             digit;

    // Digit 0 always sees a carry-in; the step strobe gates the register update,
    // so carry[DIGITS] is the "every digit saturated" wrap condition.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit_cell u_cell (
            .d    (q_r[i]),
            .up   (up),
            .cin  (carry[i]),
            .nd   (q_nxt[i]),
            .cout (carry[i+1])
        );
        assign q_ld[i] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                q_r <= q_ld;
            end else if (step) begin
                q_r  <= q_nxt;
                wrap <= carry[DIGITS];
            end
        end
    end

    assign Q = q_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            div <= div + DW'(1);
        end
    end

    always_comb begin
        digit = 4'd0;
        cat   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                digit  = q_r[i];
                cat[i] = 1'b0;
            end
        end
    end

    always_comb begin
        case (digit)
            4'd0:    seg_led = 9'h03F;
            4'd1:    seg_led = 9'h006;
            4'd2:    seg_led = 9'h05B;
            4'd3:    seg_led = 9'h04F;
            4'd4:    seg_led = 9'h066;
            4'd5:    seg_led = 9'h06D;
            4'd6:    seg_led = 9'h07D;
            4'd7:    seg_led = 9'h007;
            4'd8:    seg_led = 9'h07F;
            4'd9:    seg_led = 9'h06F;
            default: seg_led = 9'h000;
        endcase
    end
endmodule

// File: tb/tb_bcd_counter_scan.sv
// Scoreboard bench for bcd_counter_scan (DIGITS=2, SCAN_DIV=4): stimulus pushes
// expected post-edge values, a forked monitor pops and compares on negedges.

module tb_bcd_counter_scan;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       step = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] Q;
    logic       wrap;
    logic [8:0] seg_led;
    logic [1:0] cat;

    bcd_counter_scan #(.DIGITS(2), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .step(step), .up(up), .load(load),
        .load_val(load_val), .Q(Q), .wrap(wrap), .seg_led(seg_led), .cat(cat)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         due;
        logic [7:0] q;
        logic       w;
        logic       sc;
        logic [1:0] cat;
        logic [8:0] seg;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    function automatic logic [7:0] bcd(int k);
        return {4'(k / 10 % 10), 4'(k % 10)};
    endfunction

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
                e = sb.pop_front();
                checks++;
                if (Q !== e.q || wrap !== e.w) begin
                    errors++;
                    $display("FAIL count edge%0d: Q=%h wrap=%b expected Q=%h wrap=%b", e.due, Q, wrap, e.q, e.w);
                end
                if (e.sc) begin
                    checks++;
                    if (cat !== e.cat || seg_led !== e.seg) begin
                        errors++;
                        $display("FAIL scan edge%0d: cat=%b seg=%h expected cat=%b seg=%h", e.due, cat, seg_led, e.cat, e.seg);
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic s, input logic u, input logic l, input logic [7:0] lv,
                         input logic [7:0] eq, input logic ew,
                         input logic sc = 1'b0, input logic [1:0] ec = 2'b00, input logic [8:0] es = 9'h0);
        exp_t e;
        @(posedge clk);
        #1;
        step = s; up = u; load = l; load_val = lv;
        e.due = edge_cnt + 1; e.q = eq; e.w = ew; e.sc = sc; e.cat = ec; e.seg = es;
        sb.push_back(e);
    endtask

    task automatic check_reset(input string nm);
        checks++;
        if (Q !== 8'h00 || wrap !== 1'b0 || cat !== 2'b10 || seg_led !== 9'h03F) begin
            errors++;
            $display("FAIL %s: Q=%h wrap=%b cat=%b seg=%h expected Q=00 wrap=0 cat=10 seg=03f", nm, Q, wrap, cat, seg_led);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        step = 1'b0; load = 1'b0; up = 1'b0; load_val = 8'h00;
        #1;
        check_reset("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        fork
            monitor_loop();
            begin
                #500000;
                $display("FAIL watchdog: time limit reached");
                $fatal(1, "timeout");
            end
        join_none

        // Count up through the full modulus
        do_reset();
        for (int k = 1; k <= 100; k++)
            drive(1, 1, 0, 8'h00, bcd(k), (k == 100));
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        drive(0, 0, 0, 8'h00, 8'h00, 0);

        // Down from zero, then direction ignored without step
        drive(1, 0, 0, 8'h00, 8'h99, 1);
        drive(1, 0, 0, 8'h00, 8'h98, 0);
        drive(0, 1, 0, 8'h00, 8'h98, 0);

        // Loads, invalid nibble, load beats step
        drive(0, 0, 1, 8'h47, 8'h47, 0);
        drive(0, 0, 1, 8'hA3, 8'h03, 0);
        drive(1, 1, 1, 8'h12, 8'h12, 0);
        drive(1, 0, 1, 8'h0F, 8'h00, 0);
        drive(0, 0, 0, 8'h00, 8'h00, 0);
        drain();

        // Scan pattern: first drive lands on edge 2 after release
        do_reset();
        drive(0, 0, 1, 8'h58, 8'h58, 0, 1, 2'b10, 9'h07F);
        for (int j = 3; j <= 15; j++)
            drive(0, 0, 0, 8'h00, 8'h58, 0, 1,
                  ((j / 4) % 2 == 1) ? 2'b01 : 2'b10,
                  ((j / 4) % 2 == 1) ? 9'h06D : 9'h07F);
        drain();

        // Async reset while Q=73 and index=1
        do_reset();
        drive(0, 0, 1, 8'h73, 8'h73, 0, 1, 2'b10, 9'h04F);
        drive(0, 0, 0, 8'h00, 8'h73, 0, 1, 2'b10, 9'h04F);
        drive(0, 0, 0, 8'h00, 8'h73, 0, 1, 2'b01, 9'h007);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset("async_mid");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Back-to-back steps across the wrap
        drive(0, 0, 1, 8'h95, 8'h95, 0);
        for (int k = 1; k <= 10; k++)
            drive(1, 1, 0, 8'h00, bcd((95 + k) % 100), (k == 5));
        drive(0, 0, 0, 8'h00, 8'h05, 0);
        drive(0, 0, 0, 8'h00, 8'h05, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd_counter_scan.md
# bcd_counter_scan

Parametrised multi-digit synchronous 8421 BCD counter with up/down mode, parallel load, wrap flag and a time-multiplexed seven-segment scan driver. It sits after the button debouncer on the experiment board. It takes the debouncer's single-cycle pulse as its count step and drives the board's common-cathode digit array directly. It replaces single-digit ripple-clocked counting: every flop is clocked by `clk`.

## Interface
Parameters:
- DIGITS, 2, number of BCD digits (1–8); count modulus is 10^DIGITS.
- SCAN_DIV, 1000, `clk` cycles each digit is displayed before the scan advances (≥2).

Ports:
- clk  in  1  system clock; all state is updated on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- step  in  1  count-step pulse (one `clk` cycle per press, from the debouncer).
- up  in  1  direction: 1 counts up, 0 counts down; sampled with `step`.
- load  in  1  parallel-load strobe.
- load_val  in  4*DIGITS  BCD load value; digit 0 is in bits [3:0].
- Q  out  4*DIGITS  current BCD count; digit 0 is in bits [3:0].
- wrap  out  1  one-cycle flag that the count wrapped.
- seg_led  out  9  segment pattern for the selected digit: [6:0]=g..a active-high, [7]=dp, [8]=0.
- cat  out  DIGITS  digit select, active-low, one-hot.

## Operation
- Priority at each `clk` edge: `load` first, then `step`, otherwise hold.
- Load: each digit takes its `load_val` nibble.
  - Any nibble greater than 9 is loaded as 0.
  - `wrap` is 0 on a load edge.
- Step up: digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit, all in the same edge.
  - All digits at 9 roll to all 0 and `wrap` is pulsed.
- Step down: digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - All digits at 0 roll to all 9 and `wrap` is pulsed.
- `Q` only ever holds valid BCD (0–9 per digit).
- `up` has an effect only on edges where `step` is high.
- Scan divider: a counter runs 0 to SCAN_DIV-1 continuously.
  - On its terminal count, the digit index advances 0,1,…,DIGITS-1,0.
  - With DIGITS=1 the index stays 0.
- `cat` is low only at bit [index].
- `seg_led` is the decode of digit [index] of the registered `Q`:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - dp and bit 8 are always 0.
- The scan runs independently of counting. No count state is affected by the scan.

## Timing
- Reset values (rst low, applied immediately without waiting for a clock edge):
  - `Q`=0 and `wrap`=0.
  - Divider=0 and digit index=0.
  - `cat`={DIGITS-1 ones, 0} (digit 0 selected).
  - `seg_led`=0x03F.
- Release: the first active edge is the first rising `clk` edge with `rst` high.
- Latency:
  - A `step` or `load` sampled at edge N is visible on `Q` after edge N.
  - `wrap` is registered: it is high for exactly the cycle following edge N, then returns to 0.
- Back-to-back `step` on consecutive cycles: each one counts; no pulse is dropped.
- `load` and `step` high together: the load wins and the step is discarded.
- Reset mid-scan or mid-count: all state returns to reset values at once. No partial carry survives.
- `seg_led` and `cat` are combinational from registered index and `Q`. They change only after `clk` edges or on reset.
- Digit dwell: exactly SCAN_DIV cycles per digit. A full frame is DIGITS×SCAN_DIV cycles.

## Test plan
- Reset, then count up (DIGITS=2): assert `rst` low, release, apply 100 `step` pulses with `up`=1.
  - `Q` goes 0x00→0x09→0x10 … 0x99→0x00.
  - `wrap` is high for exactly one cycle after the 100th step.
- Count down from zero (DIGITS=2): from 0x00, apply one `step` with `up`=0.
  - `Q`=0x99 and `wrap` pulses once.
  - A further step gives 0x98 with `wrap`=0.
- Load, including invalid digits: `load`=1 with `load_val`=0x47, then with 0xA3.
  - `Q`=0x47, then `Q`=0x03.
  - `load` and `step` in the same cycle with `load_val`=0x12: `Q`=0x12, not 0x13.
- Scan (SCAN_DIV=4, DIGITS=2, `Q`=0x58):
  - Cycles 0–3: `cat`=2'b10 and `seg_led`=0x07F.
  - Cycles 4–7: `cat`=2'b01 and `seg_led`=0x06D.
  - The pattern then repeats.
- Asynchronous reset mid-operation: drop `rst` between clock edges while `Q`=0x73 and the index is 1.
  - Before the next edge: `Q`=0, `cat`=2'b10, `seg_led`=0x03F.
- Back-to-back steps at full rate: apply 10 consecutive cycles of `step` with `up`=1 from 0x95.
  - `Q`=0x05 and `wrap` is high exactly once (after step 5).
